// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN feature-map datapath blocks: default pixel
// width, the unpooling FSM state encoding and a counter-width helper.
package cnn_pkg;

  localparam int BIT_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    EMIT0 = 2'd2,
    EMIT1 = 2'd3
  } unpool_state_t;

  // A counter over n values still needs one bit when n is 1.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/unpool_line_buffer.sv
// One pooled row of pixels: synchronous write, combinational read.
// Contents are don't-care after reset, so the array is not reset.
module unpool_line_buffer
  import cnn_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int IN_W      = 4,
  parameter int AW        = clog2_min1(IN_W)
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [AW-1:0]               waddr,
  input  logic signed [BIT_WIDTH-1:0] wdata,
  input  logic [AW-1:0]               raddr,
  output logic signed [BIT_WIDTH-1:0] rdata
);

  logic signed [BIT_WIDTH-1:0] mem [IN_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/unpool_2x2.sv
// Nearest-neighbour 2x upsampler: buffers one pooled row, then replays it
// twice with every pixel duplicated, in raster order.
module unpool_2x2
  import cnn_pkg::*;
#(
  parameter int BIT_WIDTH = BIT_WIDTH_DEF,
  parameter int IN_W      = 4,
  parameter int IN_H      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BIT_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BIT_WIDTH-1:0] out_data,
  output logic                        out_eol,
  output logic                        out_last
);

  localparam int CIW = clog2_min1(IN_W);
  localparam int COW = $clog2(2 * IN_W);
  localparam int RIW = clog2_min1(IN_H);

  localparam logic [CIW-1:0] COL_IN_MAX  = CIW'(IN_W - 1);
  localparam logic [COW-1:0] COL_OUT_MAX = COW'(2 * IN_W - 1);
  localparam logic [RIW-1:0] ROW_IN_MAX  = RIW'(IN_H - 1);

  unpool_state_t  state, state_n;
  logic [CIW-1:0] col_in, col_in_n;
  logic [COW-1:0] col_out, col_out_n;
  logic [RIW-1:0] row_in, row_in_n;
  logic [COW-1:0] col_half;
  logic           at_row_end;
  logic signed [BIT_WIDTH-1:0] rd_data;

  assign in_ready   = (state == FILL);
  assign out_valid  = (state == EMIT0) || (state == EMIT1);
  assign at_row_end = (col_out == COL_OUT_MAX);
  assign col_half   = col_out >> 1;

  unpool_line_buffer #(
    .BIT_WIDTH (BIT_WIDTH),
    .IN_W      (IN_W),
    .AW        (CIW)
  ) u_line_buf (
    .clk   (clk),
    .we    (in_valid && in_ready),
    .waddr (col_in),
    .wdata (in_data),
    .raddr (CIW'(col_half)),
    .rdata (rd_data)
  );

  // Outputs are decoded from state only; gating keeps them 0 outside emit.
  assign out_data = out_valid ? rd_data : '0;
  assign out_eol  = out_valid && at_row_end;
  assign out_last = (state == EMIT1) && at_row_end && (row_in == ROW_IN_MAX);

  always_comb begin
    state_n   = state;
    col_in_n  = col_in;
    col_out_n = col_out;
    row_in_n  = row_in;
    case (state)
      IDLE: state_n = FILL;
      FILL: begin
        if (in_valid) begin
          if (col_in == COL_IN_MAX) begin
            col_in_n = '0;
            state_n  = EMIT0;
          end else begin
            col_in_n = col_in + 1'b1;
          end
        end
      end
      EMIT0, EMIT1: begin
        if (out_ready) begin
          if (at_row_end) begin
            col_out_n = '0;
            if (state == EMIT0) begin
              state_n = EMIT1;
            end else begin
              state_n  = FILL;
              row_in_n = (row_in == ROW_IN_MAX) ? '0 : row_in + 1'b1;
            end
          end else begin
            col_out_n = col_out + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col_in  <= '0;
      col_out <= '0;
      row_in  <= '0;
    end else begin
      state   <= state_n;
      col_in  <= col_in_n;
      col_out <= col_out_n;
      row_in  <= row_in_n;
    end
  end

endmodule

// File: tb/tb_unpool_2x2.sv
// Directed bench for unpool_2x2: three instances cover the 2x2 frame, the
// 8-bit signed variant and the 1x1 back-to-back frame case.
module tb_unpool_2x2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  iv, ir, ov, ordy, oe, ol;
  logic [31:0] id0, id1, id2;
  logic [31:0] od0, od2;
  logic [7:0]  od1;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  unpool_2x2 #(.BIT_WIDTH(32), .IN_W(2), .IN_H(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0), .out_eol(oe[0]), .out_last(ol[0])
  );

  unpool_2x2 #(.BIT_WIDTH(8), .IN_W(2), .IN_H(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id1[7:0]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1), .out_eol(oe[1]), .out_last(ol[1])
  );

  unpool_2x2 #(.BIT_WIDTH(32), .IN_W(1), .IN_H(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id2),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2), .out_eol(oe[2]), .out_last(ol[2])
  );

  function automatic logic [31:0] od(input int d);
    case (d)
      0:       return od0;
      1:       return {24'd0, od1};
      default: return od2;
    endcase
  endfunction

  task automatic set_data(input int d, input logic [31:0] v);
    case (d)
      0:       id0 = v;
      1:       id1 = v;
      default: id2 = v;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input int d, input logic [31:0] v);
    iv[d] = 1'b1;
    set_data(d, v);
    chk("in_ready_fill", {31'd0, ir[d]}, 32'd1);
    @(negedge clk);
    iv[d] = 1'b0;
  endtask

  // One output pixel; every stall cycle re-checks the same expected values.
  task automatic pixel(input int d, input logic [31:0] ev, input logic eeol,
                       input logic elast, input bit bp, input bit gate);
    int  n;
    bit  done;
    logic rdy;
    n = 0;
    done = 0;
    while (!done) begin
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      ordy[d] = rdy;
      if (gate) begin
        iv[d] = 1'b1;
        set_data(d, 32'hdead_0000 + n);
      end
      chk("out_valid", {31'd0, ov[d]}, 32'd1);
      chk("out_data", od(d), ev);
      chk("out_eol", {31'd0, oe[d]}, {31'd0, eeol});
      chk("out_last", {31'd0, ol[d]}, {31'd0, elast});
      if (gate) chk("in_ready_gated", {31'd0, ir[d]}, 32'd0);
      @(negedge clk);
      n++;
      if (rdy) done = 1;
      else if (n > 50) begin
        chk("pixel_timeout", 32'd0, 32'd1);
        done = 1;
      end
    end
    ordy[d] = 1'b0;
    if (gate) iv[d] = 1'b0;
  endtask

  task automatic frame2x2(input int d, input logic [31:0] v [4], input bit bp, input bit gate);
    for (int r = 0; r < 2; r++) begin
      feed(d, v[2*r]);
      feed(d, v[2*r+1]);
      chk("first_out_latency", {31'd0, ov[d]}, 32'd1);
      for (int k = 0; k < 8; k++)
        pixel(d, v[2*r + (k % 4) / 2], (k % 4) == 3, (r == 1) && (k == 7), bp, gate);
    end
  endtask

  task automatic check_reset_outputs(input int d);
    chk("rst_in_ready", {31'd0, ir[d]}, 32'd0);
    chk("rst_out_valid", {31'd0, ov[d]}, 32'd0);
    chk("rst_out_eol", {31'd0, oe[d]}, 32'd0);
    chk("rst_out_last", {31'd0, ol[d]}, 32'd0);
    chk("rst_out_data", od(d), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("ready_after_release", {31'd0, ir[0]}, 32'd0);
    @(negedge clk);
    chk("ready_one_cycle_later", {31'd0, ir[0]}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    iv = '0;
    ordy = '0;
    id0 = '0;
    id1 = '0;
    id2 = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_reset_outputs(d);
    release_reset();

    // Basic frame, full-rate downstream.
    frame2x2(0, '{32'd1, 32'd2, 32'd3, 32'd4}, 1'b0, 1'b0);
    // Same frame with random backpressure.
    frame2x2(0, '{32'd1, 32'd2, 32'd3, 32'd4}, 1'b1, 1'b0);
    // in_valid held with junk data throughout emit.
    frame2x2(0, '{32'd11, 32'd12, 32'd13, 32'd14}, 1'b0, 1'b1);

    // Reset during EMIT1 of row 0.
    feed(0, 32'd21);
    feed(0, 32'd22);
    for (int k = 0; k < 5; k++)
      pixel(0, (k % 4) < 2 ? 32'd21 : 32'd22, (k % 4) == 3, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    release_reset();
    frame2x2(0, '{32'd5, 32'd6, 32'd7, 32'd8}, 1'b0, 1'b0);

    // 8-bit signed extremes pass bit-exact.
    frame2x2(1, '{32'h80, 32'h7f, 32'hff, 32'h00}, 1'b1, 1'b0);

    // IN_W=1, IN_H=1: back-to-back frames.
    feed(2, 32'd9);
    chk("c_latency", {31'd0, ov[2]}, 32'd1);
    for (int k = 0; k < 4; k++) pixel(2, 32'd9, (k % 2) == 1, k == 3, 1'b0, 1'b0);
    chk("c_ready_after_last", {31'd0, ir[2]}, 32'd1);
    feed(2, 32'd10);
    for (int k = 0; k < 4; k++) pixel(2, 32'd10, (k % 2) == 1, k == 3, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/unpool_2x2.md
Name: unpool_2x2

Overview:
- Inverse of the 2x2 max-pooling stage: nearest-neighbour 2x upsampler for one feature-map channel.
- Accepts a pooled map of IN_W x IN_H signed values in raster order over valid/ready.
- Emits a (2*IN_W) x (2*IN_H) map in raster order, one pixel per cycle, over valid/ready.
- Sits on the decoder/upsampling path, mirroring the row-pair pooling datapath.

Parameters:
- BIT_WIDTH, 32, signed pixel width.
- IN_W, 4, pooled row width in pixels (>=1).
- IN_H, 4, pooled rows per frame (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a pooled pixel.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  BIT_WIDTH  signed pooled pixel.
- out_valid  output  1  out_data holds an upsampled pixel.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  BIT_WIDTH  signed upsampled pixel.
- out_eol  output  1  out_data is the last pixel of an output row.
- out_last  output  1  out_data is the last pixel of the output frame.

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE and all counters clear. in_ready, out_valid, out_eol and out_last are 0; out_data is 0.
- Reset mid-operation: the partial frame is discarded. Line-buffer contents are don't-care.
- Transfer rules: input is transferred when in_valid && in_ready; output is transferred when out_valid && out_ready.
- States and transitions:
  - IDLE: in_ready=0, out_valid=0. Goes to FILL unconditionally on the next cycle.
  - FILL: in_ready=1, out_valid=0.
    - Each input transfer writes line_buf[col_in] and increments col_in.
    - On the transfer with col_in==IN_W-1, col_in wraps to 0 and the state goes to EMIT0.
  - EMIT0 / EMIT1: in_ready=0, so in_valid is ignored. out_valid=1.
    - out_data = line_buf[col_out>>1], with col_out in 0..2*IN_W-1.
    - Each output transfer increments col_out.
    - out_eol=1 when col_out==2*IN_W-1.
    - On the transfer at col_out==2*IN_W-1: col_out wraps to 0. EMIT0 goes to EMIT1. EMIT1 goes to FILL and increments row_in.
    - out_last=1 in EMIT1 when col_out==2*IN_W-1 and row_in==IN_H-1. On that transfer, row_in wraps to 0 and the next frame starts in FILL (no return to IDLE).
- Stall: while out_valid && !out_ready, out_data, out_eol and out_last hold stable and no counter changes.
- Latency: the first output pixel is valid the cycle after the IN_W-th input transfer of a row.
- Rate: each pooled row costs IN_W input cycles plus 4*IN_W output cycles. There is no fill/emit overlap.
- Arithmetic: no arithmetic on data. Values pass bit-exact with sign preserved; negative values are replicated unchanged.
- Counter widths:
  - col_in: $clog2(IN_W), minimum 1.
  - col_out: $clog2(2*IN_W).
  - row_in: $clog2(IN_H), minimum 1.
- Boundaries:
  - IN_W=1: each row emits 2 pixels twice.
  - IN_H=1: out_last fires on the 4*IN_W-th output of the frame.
  - Simultaneous in_valid and out_ready cannot both transfer, because the states are exclusive.
- Per frame: exactly 4*IN_W*IN_H output transfers and exactly one out_last.

Decomposition:
- Shared package/header (cnn_pkg): default BIT_WIDTH, state encoding localparams (IDLE, FILL, EMIT0, EMIT1), and the clog2-with-minimum-1 helper.
- Sub-module unpool_line_buffer: IN_W x BIT_WIDTH register array with one synchronous write port and one combinational read port. Not reset.
- The top level holds the FSM, the counters and the flag decode.

Test Plan:
- Basic frame: IN_W=2, IN_H=2, out_ready=1, inputs 1,2,3,4.
  - Outputs are 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4.
  - out_eol on outputs 4, 8, 12 and 16; out_last only on output 16.
- Backpressure: same stimulus, out_ready toggling 1,0,0,1,... (pseudo-random).
  - Identical output sequence.
  - out_data, out_eol and out_last stay stable during every stall cycle.
- Signed and width: BIT_WIDTH=8, inputs -128, 127, -1, 0.
  - Outputs are -128,-128,127,127 (twice), then -1,-1,0,0 (twice). Bit patterns are preserved.
- Input gating: hold in_valid=1 with changing data during EMIT0/EMIT1.
  - in_ready=0 throughout and no buffer writes; the next FILL captures only post-EMIT data.
- Reset mid-emit: assert rst_n=0 during EMIT1 of row 0.
  - Outputs drop to 0 immediately; the state is IDLE.
  - After release, in_ready rises one cycle later, and a fresh frame 5,6,7,8 produces the correct 16-pixel sequence with out_last on pixel 16.
- Back-to-back frames: two frames fed continuously, IN_W=1, IN_H=1.
  - Frame 1 input 9 gives 9,9,9,9 with out_last on pixel 4.
  - in_ready is 1 the cycle after that transfer, and frame 2 input 10 gives 10,10,10,10.
